// File: rtl/xor_parity_pkg.sv
// Shared definitions for the XOR-parity serial receiver: FSM state
// encoding and the sizing rule for the data-bit counter.
package xor_parity_pkg;

   // Receiver FSM states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_t;

   // Counter width needed to count 0..data_w inclusive.
   function automatic int cnt_w(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/xor_parity_acc.sv
// Running XOR of the received data bits. Cleared when a start bit is
// accepted, folds in one bit per enabled cycle, holds otherwise.
module xor_parity_acc (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   input  logic in_bit,
   output logic acc
);

   // Clear has priority over accumulate; reset has priority over both.
   always_ff @(posedge clk) begin
      if (!rstn)
         acc <= 1'b0;
      else if (clr)
         acc <= 1'b0;
      else if (en)
         acc <= acc ^ in_bit;
   end

endmodule

// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB first, one parity
// bit, one stop(1). Samples sin only on bit_en strobes. Good frames update
// data and pulse valid with the parity check result; a bad stop bit pulses
// frame_err and leaves data alone.
module xor_parity_rx
   import xor_parity_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              bit_en,
   input  logic              sin,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int   CNT_W = cnt_w(DATA_W);
   localparam logic ODD   = (PARITY_ODD != 0);

   rx_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;
   logic              err;
   logic              acc;
   logic              acc_clr;
   logic              acc_en;

   // A start bit seen in IDLE restarts the parity sum; data samples fold in.
   assign acc_clr = bit_en && (state == ST_IDLE) && !sin;
   assign acc_en  = bit_en && (state == ST_DATA);

   xor_parity_acc u_acc (
      .clk    (clk),
      .rstn   (rstn),
      .clr    (acc_clr),
      .en     (acc_en),
      .in_bit (sin),
      .acc    (acc)
   );

   // Frame FSM with registered outputs; only bit_en cycles advance it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         shreg      <= '0;
         err        <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // Completion flags are single-cycle pulses.
         valid     <= 1'b0;
         frame_err <= 1'b0;
         if (bit_en) begin
            case (state)
               ST_IDLE: begin
                  if (!sin) begin
                     state <= ST_DATA;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end
               end
               ST_DATA: begin
                  // Place each sample at its bit position, LSB first.
                  for (int i = 0; i < DATA_W; i++) begin
                     if (cnt == CNT_W'(i))
                        shreg[i] <= sin;
                  end
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(DATA_W - 1))
                     state <= ST_PARITY;
               end
               ST_PARITY: begin
                  // Held until the stop bit decides whether it is reported.
                  err   <= acc ^ sin ^ ODD;
                  state <= ST_STOP;
               end
               ST_STOP: begin
                  if (sin) begin
                     data       <= shreg;
                     valid      <= 1'b1;
                     parity_err <= err;
                  end else begin
                     frame_err  <= 1'b1;
                  end
                  // No hunting for a line edge: next strobe is a start candidate.
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_xor_parity_rx.sv
// Bench for xor_parity_rx: one even-parity and one odd-parity instance
// share the serial line. Expected words and parity flags come from a
// frame-level model (XOR reduction of the word and parity bit).
module tb_xor_parity_rx;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       bit_en = 1'b0;
   logic       sin = 1'b1;

   logic [7:0] data0, data1;
   logic       valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;

   logic [7:0] o_data [2];
   logic       o_valid [2];
   logic       o_perr [2];
   logic       o_ferr [2];
   logic       o_busy [2];

   int checks = 0;
   int errors = 0;

   // reference model state, per instance (0 = even, 1 = odd)
   logic [7:0] m_data [2];
   logic       m_perr [2];
   int         exp_v = 0;
   int         exp_f = 0;

   // observed pulse counts
   int vcnt [2] = '{0, 0};
   int fcnt [2] = '{0, 0};
   int both_cnt = 0;

   always #5 clk = ~clk;

   xor_parity_rx #(.DATA_W(8), .PARITY_ODD(0)) u_even (
      .clk(clk), .rstn(rstn), .bit_en(bit_en), .sin(sin),
      .data(data0), .valid(valid0), .parity_err(perr0),
      .frame_err(ferr0), .busy(busy0)
   );

   xor_parity_rx #(.DATA_W(8), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rstn(rstn), .bit_en(bit_en), .sin(sin),
      .data(data1), .valid(valid1), .parity_err(perr1),
      .frame_err(ferr1), .busy(busy1)
   );

   always_comb begin
      o_data[0] = data0;  o_data[1] = data1;
      o_valid[0] = valid0; o_valid[1] = valid1;
      o_perr[0] = perr0;  o_perr[1] = perr1;
      o_ferr[0] = ferr0;  o_ferr[1] = ferr1;
      o_busy[0] = busy0;  o_busy[1] = busy1;
   end

   always @(negedge clk) begin
      if (valid0) vcnt[0]++;
      if (valid1) vcnt[1]++;
      if (ferr0)  fcnt[0]++;
      if (ferr1)  fcnt[1]++;
      if ((valid0 && ferr0) || (valid1 && ferr1)) both_cnt++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic model_err(input logic [7:0] d, input logic p, input int k);
      return (^d) ^ p ^ (k == 1);
   endfunction

   // Drive one frame; each bit gets gap-1 idle strobes (random sin) first.
   task automatic run_frame(input logic [7:0] d, input logic p, input logic s,
                            input int gap, input string tag);
      logic [10:0] bits;
      logic        xb;
      bits = {s, p, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         for (int g = 0; g < gap - 1; g++) begin
            bit_en = 1'b0;
            sin = 1'($urandom_range(0, 1));
            tick();
            xb = (i > 0);
            checks++;
            if (busy0 !== xb || busy1 !== xb) begin
               errors++;
               $display("FAIL %s busy_gap bit%0d: got %0b/%0b expected %0b", tag, i, busy0, busy1, xb);
            end
         end
         bit_en = 1'b1;
         sin = bits[i];
         tick();
         if (i < 10) begin
            checks++;
            if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
               errors++;
               $display("FAIL %s busy bit%0d: got %0b/%0b expected 1", tag, i, busy0, busy1);
            end
         end
      end
      bit_en = 1'b0;
      sin = 1'b1;
      if (s) exp_v++; else exp_f++;
      // one clk after the stop sample
      for (int k = 0; k < 2; k++) begin
         if (s) begin
            m_data[k] = d;
            m_perr[k] = model_err(d, p, k);
         end
         checks++;
         if (o_valid[k] !== s || o_ferr[k] !== !s) begin
            errors++;
            $display("FAIL %s pulse inst%0d: valid=%0b frame_err=%0b expected %0b/%0b",
                     tag, k, o_valid[k], o_ferr[k], s, !s);
         end
         checks++;
         if (o_data[k] !== m_data[k] || o_perr[k] !== m_perr[k]) begin
            errors++;
            $display("FAIL %s result inst%0d: data=%h parity_err=%0b expected %h/%0b",
                     tag, k, o_data[k], o_perr[k], m_data[k], m_perr[k]);
         end
         checks++;
         if (o_busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_end inst%0d: got %0b expected 0", tag, k, o_busy[k]);
         end
      end
      tick();
      // pulses are single-cycle; parity_err and data hold
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_valid[k] !== 1'b0 || o_ferr[k] !== 1'b0 ||
             o_data[k] !== m_data[k] || o_perr[k] !== m_perr[k]) begin
            errors++;
            $display("FAIL %s hold inst%0d: valid=%0b frame_err=%0b data=%h perr=%0b expected 0/0/%h/%0b",
                     tag, k, o_valid[k], o_ferr[k], o_data[k], o_perr[k], m_data[k], m_perr[k]);
         end
      end
   endtask

   task automatic check_cleared(input string tag);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_data[k] !== 8'h00 || o_valid[k] !== 1'b0 || o_perr[k] !== 1'b0 ||
             o_ferr[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s inst%0d: data=%h valid=%0b perr=%0b ferr=%0b busy=%0b expected all 0",
                     tag, k, o_data[k], o_valid[k], o_perr[k], o_ferr[k], o_busy[k]);
         end
         m_data[k] = 8'h00;
         m_perr[k] = 1'b0;
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0; bit_en = 1'b1; sin = 1'b0;
      tick(); tick();
      check_cleared("reset");
      bit_en = 1'b0; sin = 1'b1;
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_directed;
      run_frame(8'hA5, 1'b0, 1'b1, 1, "a5_even");
      run_frame(8'h01, 1'b0, 1'b1, 1, "01_perr");
      run_frame(8'h3C, 1'b0, 1'b0, 1, "3c_badstop");
   endtask

   task automatic test_slow_strobe;
      run_frame(8'hA5, 1'b0, 1'b1, 3, "a5_every3");
   endtask

   task automatic test_reset_mid;
      int v0, f0;
      logic [4:0] head;
      head = 5'b01010;                // start + 4 data bits
      for (int i = 0; i < 5; i++) begin
         bit_en = 1'b1; sin = head[i];
         tick();
      end
      v0 = vcnt[0] + vcnt[1];
      f0 = fcnt[0] + fcnt[1];
      rstn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bit_en = 1'b1; sin = 1'($urandom_range(0, 1));
         tick();
      end
      check_cleared("reset_mid");
      checks++;
      if (vcnt[0] + vcnt[1] !== v0 || fcnt[0] + fcnt[1] !== f0) begin
         errors++;
         $display("FAIL reset_mid_pulses: valid/frame_err counts %0d/%0d expected %0d/%0d",
                  vcnt[0] + vcnt[1], fcnt[0] + fcnt[1], v0, f0);
      end
      bit_en = 1'b0; sin = 1'b1;
      rstn = 1'b1;
      tick();
      run_frame(8'h3C, 1'b0, 1'b1, 1, "3c_after_reset");
   endtask

   task automatic test_odd_parity;
      run_frame(8'h00, 1'b1, 1'b1, 1, "00_p1");
      run_frame(8'h00, 1'b0, 1'b1, 2, "00_p0");
   endtask

   task automatic test_random;
      int n_idle;
      for (int f = 0; f < 40; f++) begin
         n_idle = $urandom_range(0, 3);
         for (int c = 0; c < n_idle; c++) begin
            bit_en = 1'($urandom_range(0, 1));
            sin = bit_en ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
         end
         run_frame(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
                   $urandom_range(1, 3), "random");
      end
   endtask

   task automatic test_back_to_back;
      for (int f = 0; f < 6; f++)
         run_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1, "b2b");
      tick();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL pulse_overlap: valid with frame_err seen %0d times, expected 0", both_cnt);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (vcnt[k] != exp_v || fcnt[k] != exp_f) begin
            errors++;
            $display("FAIL pulse_count inst%0d: valid=%0d frame_err=%0d expected %0d/%0d",
                     k, vcnt[k], fcnt[k], exp_v, exp_f);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_slow_strobe();
      test_reset_mid();
      test_odd_parity();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xor_parity_rx.md
XOR_PARITY_RX -- requirements
Module: xor_parity_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data bits per frame (legal range 1..16).
REQ-002 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 clk  input  1  the single clock; all state changes SHALL occur on its rising edge.
REQ-004 rstn  input  1  reset, synchronous and active-low.
REQ-005 bit_en  input  1  sample strobe; sin SHALL be sampled only in cycles with bit_en=1.
REQ-006 sin  input  1  serial line; idles high.
REQ-007 data  output  DATA_W  last good received word, LSB received first.
REQ-008 valid  output  1  one-cycle pulse when a frame completes with a correct stop bit.
REQ-009 parity_err  output  1  qualified by valid; 1 when the received parity fails the XOR check.
REQ-010 frame_err  output  1  one-cycle pulse when the stop bit samples 0.
REQ-011 busy  output  1  high while the state is not IDLE.

Function
REQ-012 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, one parity bit, one stop bit (1).
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL advance only on cycles with bit_en=1.
REQ-014 IDLE: with bit_en=1 and sin=0, the FSM SHALL go to DATA and clear the bit counter and parity accumulator; with sin=1 it SHALL stay in IDLE.
REQ-015 DATA: each sample SHALL be shifted into the shift register at bit position count and XORed into the accumulator (acc <= acc ^ sin).
REQ-016 DATA: after the DATA_W-th sample the FSM SHALL go to PARITY.
REQ-017 PARITY: the block SHALL compute err = acc ^ sin ^ PARITY_ODD and then go to STOP.
REQ-018 STOP, sin=1: in the following cycle data SHALL load the shift register, valid=1 and parity_err=err.
REQ-019 STOP, sin=0: in the following cycle frame_err=1, valid=0, and data SHALL be unchanged.
REQ-020 From STOP the FSM SHALL always return to IDLE; the next bit_en sample is treated as a candidate start bit, with no re-synchronisation.
REQ-021 valid and frame_err SHALL be single-cycle pulses and SHALL never be asserted together.
REQ-022 parity_err SHALL hold its value until the next valid pulse.
REQ-023 Cycles with bit_en=0 SHALL hold all state; latency from the stop-bit sample to the valid or frame_err pulse SHALL be exactly 1 clk.
REQ-024 busy SHALL go high in the cycle after the start bit is sampled and low in the cycle the FSM re-enters IDLE.

Reset
REQ-025 On a rising clk edge with rstn=0: state=IDLE; counter, accumulator, shift register and data SHALL be 0; valid, parity_err, frame_err and busy SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse; reception SHALL restart at the next start bit after rstn=1.
REQ-027 Reset SHALL take priority over bit_en.

Structure
REQ-028 Package xor_parity_pkg SHALL hold the FSM state encoding (2 bits) and the counter width function clog2(DATA_W+1).
REQ-029 The parity accumulator SHALL be a sub-module xor_parity_acc (inputs clr, en, bit; output acc), used once.
REQ-030 No logic other than the FSM, counter, shift register and output registers SHALL be present.

Verification
REQ-031 Default params, frame 0xA5 with parity bit 0 and stop bit 1 -> valid=1, data=0xA5, parity_err=0, 1 clk after the stop sample.
REQ-032 Frame 0x01 with parity bit 0 -> valid=1, data=0x01, parity_err=1.
REQ-033 Frame 0x3C followed by stop bit 0 -> frame_err=1, valid=0, data keeps its prior value.
REQ-034 0xA5 frame sent with bit_en=1 only every 3rd cycle -> same result as REQ-031; busy stays high throughout the frame.
REQ-035 rstn=0 after 4 data bits, then release and send frame 0x3C with parity 0 -> no pulse during reset, then valid=1 and data=0x3C.
REQ-036 PARITY_ODD=1, frame 0x00 with parity bit 1 -> parity_err=0; the same frame with parity bit 0 -> parity_err=1.
